// File: rtl/sched_pkg.sv
// Shared types and round-robin pick helper for the resource scheduler.
package sched_pkg;

    typedef enum logic {IDLE, OWN} state_t;

    localparam int unsigned BURST_W   = 4;
    localparam int unsigned MAX_LANES = 8;

    // One-hot first set bit of mask[n-1:0], searching upward from ptr with wrap.
    function automatic logic [MAX_LANES-1:0] rr_pick(input logic [MAX_LANES-1:0] mask,
                                                     input logic [2:0] ptr,
                                                     input int unsigned n);
        logic [MAX_LANES-1:0] res;
        logic                 found;
        int unsigned          idx;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !found && mask[3'(idx)]) begin
                res[3'(idx)] = 1'b1;
                found        = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_resource_scheduler_if.sv
// Lane handshake bundle between requesters and the scheduler.
// Carries preempt only when RR_SCHED_STALL_PREEMPT_EN is defined.
interface rr_resource_scheduler_if
    import sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] stall;
    logic [NUM_REQ-1:0] flush;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [NUM_REQ-1:0] fire;
    logic [BURST_W-1:0] burst_cnt;
`ifdef RR_SCHED_STALL_PREEMPT_EN
    logic               preempt;

    modport master (output req, stall, flush,
                    input  grant, grant_idx, grant_valid, fire, burst_cnt, preempt);
    modport slave  (input  req, stall, flush,
                    output grant, grant_idx, grant_valid, fire, burst_cnt, preempt);
`else
    modport master (output req, stall, flush,
                    input  grant, grant_idx, grant_valid, fire, burst_cnt);
    modport slave  (input  req, stall, flush,
                    output grant, grant_idx, grant_valid, fire, burst_cnt);
`endif
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational rotate-and-find-first over N lanes starting at ptr.
module rr_priority_pick
    import sched_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    assign onehot = N'(rr_pick(MAX_LANES'(mask), 3'(ptr), N));
    assign any    = |mask;

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (onehot[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/rr_resource_scheduler.sv
// Registered round-robin grant of one shared datapath among NUM_REQ lanes with burst fairness.
// Optional stalled-owner preemption under RR_SCHED_STALL_PREEMPT_EN.
module rr_resource_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned MAX_BURST   = 4,
`ifdef RR_SCHED_STALL_PREEMPT_EN
    parameter int unsigned STALL_LIMIT = 8,
`endif
    parameter int unsigned IDX_W       = $clog2(NUM_REQ)
) (
    input  logic clk,
    input  logic reset,
    rr_resource_scheduler_if.slave bus
);
    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [NUM_REQ-1:0] others;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_ptr, pick_idx, next_idx;
    logic               pick_any, handoff;
`ifdef RR_SCHED_STALL_PREEMPT_EN
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               preempt_q, preempt_d;
`endif

    // Candidates exclude the current owner; in IDLE grant_q is zero so this is just eff.
    assign others   = bus.req & ~bus.flush & ~grant_q;
    assign next_idx = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
    assign pick_ptr = (state_q == OWN) ? next_idx : ptr_q;

    rr_priority_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .mask   (others),
        .ptr    (pick_ptr),
        .onehot (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        handoff   = 1'b0;
`ifdef RR_SCHED_STALL_PREEMPT_EN
        stall_d   = stall_q;
        preempt_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = OWN;
                    handoff = 1'b1;
                end
            end
            OWN: begin
                if (bus.flush[idx_q] || !bus.req[idx_q]) begin
                    ptr_d   = next_idx;
                    burst_d = '0;
                    if (pick_any) begin
                        handoff = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                    end
                end else if (bus.stall[idx_q]) begin
`ifdef RR_SCHED_STALL_PREEMPT_EN
                    if (stall_q >= STALL_W'(STALL_LIMIT - 1) && pick_any) begin
                        ptr_d     = next_idx;
                        handoff   = 1'b1;
                        preempt_d = 1'b1;
                    end else if (stall_q < STALL_W'(STALL_LIMIT)) begin
                        stall_d = stall_q + STALL_W'(1);
                    end
`endif
                end else begin
                    // Owner fires: rotate on a full burst if anyone else waits, else saturate.
`ifdef RR_SCHED_STALL_PREEMPT_EN
                    stall_d = '0;
`endif
                    if (burst_q >= BURST_W'(MAX_BURST - 1) && pick_any) begin
                        ptr_d   = next_idx;
                        handoff = 1'b1;
                    end else if (burst_q < BURST_W'(MAX_BURST)) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (handoff) begin
            grant_d = pick_grant;
            idx_d   = pick_idx;
            burst_d = '0;
`ifdef RR_SCHED_STALL_PREEMPT_EN
            stall_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
        end
    end

`ifdef RR_SCHED_STALL_PREEMPT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q   <= '0;
            preempt_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.preempt = preempt_q;
`endif

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = |grant_q;
    assign bus.burst_cnt   = burst_q;
    assign bus.fire        = grant_q & bus.req & ~bus.stall & ~bus.flush;
endmodule

// File: tb/tb_rr_resource_scheduler.sv
// Directed bench for rr_resource_scheduler: lane-ownership model checked every cycle plus literal pins.
module tb_rr_resource_scheduler;
    localparam int unsigned N  = 2;
    localparam int unsigned MB = 4;
`ifdef RR_SCHED_STALL_PREEMPT_EN
    localparam int unsigned SL = 8;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    rr_resource_scheduler_if #(.NUM_REQ(N)) bus ();

    rr_resource_scheduler #(
        .NUM_REQ     (N),
`ifdef RR_SCHED_STALL_PREEMPT_EN
        .STALL_LIMIT (SL),
`endif
        .MAX_BURST   (MB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: who owns the resource, how many transfers it has made, where the search starts next.
    int m_owner = -1;
    int m_burst = 0;
    int m_ptr   = 0;
    int m_stall = 0;
    bit m_pre   = 1'b0;

    function automatic int pick(input logic [N-1:0] m, input int start);
        for (int i = 0; i < int'(N); i++) begin
            int l = (start + i) % int'(N);
            if (m[l]) return l;
        end
        return -1;
    endfunction

    int             no, nb, np, ns, o;
    bit             npre;
    logic [N-1:0]   eff, oth;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner <= -1;
            m_burst <= 0;
            m_ptr   <= 0;
            m_stall <= 0;
            m_pre   <= 1'b0;
        end else begin
            eff  = bus.req & ~bus.flush;
            no   = m_owner;
            nb   = m_burst;
            np   = m_ptr;
            ns   = m_stall;
            npre = 1'b0;
            if (m_owner < 0) begin
                if (eff != '0) begin
                    no = pick(eff, m_ptr);
                    nb = 0;
                    ns = 0;
                end
            end else begin
                o      = m_owner;
                oth    = eff;
                oth[o] = 1'b0;
                if (bus.flush[o] || !bus.req[o]) begin
                    np = (o + 1) % int'(N);
                    nb = 0;
                    ns = 0;
                    no = pick(oth, np);
                end else if (bus.stall[o]) begin
`ifdef RR_SCHED_STALL_PREEMPT_EN
                    if (m_stall + 1 >= int'(SL) && oth != '0) begin
                        np   = (o + 1) % int'(N);
                        no   = pick(oth, np);
                        nb   = 0;
                        ns   = 0;
                        npre = 1'b1;
                    end else if (m_stall < int'(SL)) begin
                        ns = m_stall + 1;
                    end
`endif
                end else begin
                    ns = 0;
                    if (m_burst + 1 >= int'(MB) && oth != '0) begin
                        np = (o + 1) % int'(N);
                        no = pick(oth, np);
                        nb = 0;
                    end else begin
                        nb = (m_burst + 1 > int'(MB)) ? int'(MB) : m_burst + 1;
                    end
                end
            end
            m_owner <= no;
            m_burst <= nb;
            m_ptr   <= np;
            m_stall <= ns;
            m_pre   <= npre;
        end
    end

    // Compare process: outputs vs model, mid-cycle.
    int exp_g;
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            exp_g = (m_owner < 0) ? 0 : (1 << m_owner);
            check("grant",       int'(bus.grant),       exp_g);
            check("grant_idx",   int'(bus.grant_idx),   (m_owner < 0) ? 0 : m_owner);
            check("grant_valid", int'(bus.grant_valid), (m_owner < 0) ? 0 : 1);
            check("burst_cnt",   int'(bus.burst_cnt),   m_burst);
            check("fire",        int'(bus.fire),
                  exp_g & int'(bus.req) & ~int'(bus.stall) & ~int'(bus.flush));
`ifdef RR_SCHED_STALL_PREEMPT_EN
            check("preempt",     int'(bus.preempt),     int'(m_pre));
`endif
        end
    end

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] s,
                        input logic [N-1:0] f, input int n);
        repeat (n) begin
            bus.req   = r;
            bus.stall = s;
            bus.flush = f;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.req   = '0;
        bus.stall = '0;
        bus.flush = '0;
        repeat (2) @(posedge clk);
        #1 reset  = 1'b0;
        chk_en    = 1'b1;
        check("pin_rst_grant", int'(bus.grant),       0);
        check("pin_rst_idx",   int'(bus.grant_idx),   0);
        check("pin_rst_valid", int'(bus.grant_valid), 0);
        check("pin_rst_burst", int'(bus.burst_cnt),   0);

        // Both lanes request: lane 0 first, 4 fires, then lane 1.
        step(2'b11, 2'b00, 2'b00, 1);
        check("pin_first_grant", int'(bus.grant),     1);
        check("pin_first_idx",   int'(bus.grant_idx), 0);
        check("pin_first_fire",  int'(bus.fire),      1);
        step(2'b11, 2'b00, 2'b00, 3);
        check("pin_burst3_grant", int'(bus.grant),     1);
        check("pin_burst3_cnt",   int'(bus.burst_cnt), 3);
        step(2'b11, 2'b00, 2'b00, 1);
        check("pin_rotate_grant", int'(bus.grant),     2);
        check("pin_rotate_cnt",   int'(bus.burst_cnt), 0);
        step(2'b11, 2'b00, 2'b00, 7);

        // Idle, then lane 0 owns and stalls while lane 1 waits.
        step(2'b00, 2'b00, 2'b00, 2);
        step(2'b01, 2'b00, 2'b00, 1);
        check("pin_own0", int'(bus.grant), 1);
        step(2'b11, 2'b01, 2'b00, 10);
`ifdef RR_SCHED_STALL_PREEMPT_EN
        check("pin_stall_grant", int'(bus.grant), 2);
`else
        check("pin_stall_grant", int'(bus.grant),     1);
        check("pin_stall_cnt",   int'(bus.burst_cnt), 0);
`endif

        // Flush lane 0 while lane 1 requests; then lane 1 alone saturates.
        step(2'b11, 2'b00, 2'b01, 1);
        check("pin_flush_grant", int'(bus.grant), 2);
        step(2'b10, 2'b00, 2'b00, 10);
        check("pin_sat_grant", int'(bus.grant),     2);
        check("pin_sat_cnt",   int'(bus.burst_cnt), 4);

        // Flush of every lane goes idle; non-owner flush masks lane 1.
        step(2'b11, 2'b00, 2'b11, 1);
        check("pin_allflush_grant", int'(bus.grant), 0);
        step(2'b11, 2'b00, 2'b10, 2);
        step(2'b00, 2'b00, 2'b00, 1);
        step(2'b11, 2'b00, 2'b00, 1);
        check("pin_ptr1_grant", int'(bus.grant), 2);
        step(2'b11, 2'b00, 2'b00, 1);

        // Async reset mid-transfer, then arbitration restarts from lane 0.
        #2 reset = 1'b1;
        #1;
        check("pin_async_grant", int'(bus.grant),     0);
        check("pin_async_burst", int'(bus.burst_cnt), 0);
        check("pin_async_fire",  int'(bus.fire),      0);
        check("pin_async_valid", int'(bus.grant_valid), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("pin_after_rst_grant", int'(bus.grant), 1);
        step(2'b11, 2'b00, 2'b00, 6);
        step(2'b01, 2'b10, 2'b00, 3);
        step(2'b00, 2'b00, 2'b00, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
